mips_reg_file: RTL and testbench

32-entry × 32-bit general-purpose register file for the 32-bit MIPS datapath. It has two asynchronous read ports (rs/rt operands) and one synchronous write port (rd/rt writeback). Register 0 is hardwired to zero per the MIPS ISA. It sits between instruction decode and the ALU, with writeback fed from the MEM/WB stage.

---
 rtl/mips_reg_file.sv | 97 +++++++++
 tb/tb_mips_reg_file.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mips_reg_file.sv
// mips_reg_file
//   32 x 32-bit MIPS general-purpose register file.
//   Two combinational read ports and one synchronous write port.
//   r0 is hardwired to zero.
//   A write in flight is forwarded to a read port that addresses the same
//   register, so decode sees writeback data in the same cycle.
//
// Ports
//   clk     in   system clock; writes happen on its rising edge
//   rst_n   in   asynchronous active-low reset; clears every register
//   wr      in   write enable for the write port
//   addr1   in   read port 1 address
//   addr2   in   read port 2 address
//   addr3   in   write port address
//   data3   in   write data
//   rdout1  out  read port 1 data (combinational)
//   rdout2  out  read port 2 data (combinational)
module mips_reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [ADDR_WIDTH-1:0] addr2,
  input  logic [ADDR_WIDTH-1:0] addr3,
  input  logic [DATA_WIDTH-1:0] data3,
  output logic [DATA_WIDTH-1:0] rdout1,
  output logic [DATA_WIDTH-1:0] rdout2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic                  wr_en_s;

  // A write to r0 is discarded, so it never counts as a live write.
  assign wr_en_s = wr && (addr3 != {ADDR_WIDTH{1'b0}});

  // Next-state storage: hold everything, update the addressed register on a live write.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en_s) begin
      regs_d[addr3] = data3;
    end else begin
      regs_d[addr3] = regs_q[addr3];
    end
    // r0 stays a constant zero, so its flop folds away.
    regs_d[0] = {DATA_WIDTH{1'b0}};
  end

  // Storage flops; async reset clears every register immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read port 1. The rst_n gate keeps the bypass quiet while in reset.
  always_comb begin
    rdout1 = {DATA_WIDTH{1'b0}};
    if (!rst_n) begin
      rdout1 = {DATA_WIDTH{1'b0}};
    end else if (addr1 == {ADDR_WIDTH{1'b0}}) begin
      rdout1 = {DATA_WIDTH{1'b0}};
    end else if (wr_en_s && (addr1 == addr3)) begin
      rdout1 = data3;
    end else begin
      rdout1 = regs_q[addr1];
    end
  end

  // Read port 2 follows the same rules as port 1.
  always_comb begin
    rdout2 = {DATA_WIDTH{1'b0}};
    if (!rst_n) begin
      rdout2 = {DATA_WIDTH{1'b0}};
    end else if (addr2 == {ADDR_WIDTH{1'b0}}) begin
      rdout2 = {DATA_WIDTH{1'b0}};
    end else if (wr_en_s && (addr2 == addr3)) begin
      rdout2 = data3;
    end else begin
      rdout2 = regs_q[addr2];
    end
  end

endmodule

// File: tb/tb_mips_reg_file.sv
// Testbench for mips_reg_file.
// It keeps a behavioural array model, compares both read ports against that
// model on every falling clock edge, and also checks the directed scenarios
// against hand-computed literals.
module tb_mips_reg_file;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b1;
  logic        wr     = 1'b0;
  logic [4:0]  addr1  = 5'd0;
  logic [4:0]  addr2  = 5'd0;
  logic [4:0]  addr3  = 5'd0;
  logic [31:0] data3  = 32'd0;
  logic [31:0] rdout1;
  logic [31:0] rdout2;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  // Behavioural model: plain array of register contents.
  logic [31:0] mdl [32];

  mips_reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr     (wr),
    .addr1  (addr1),
    .addr2  (addr2),
    .addr3  (addr3),
    .data3  (data3),
    .rdout1 (rdout1),
    .rdout2 (rdout2)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
  end

  // Model: reset clears everything at once.
  always @(negedge rst_n) begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
  end

  // Model: a write lands on the rising edge only when out of reset and not r0.
  always @(posedge clk) begin
    if (rst_n && wr && addr3 != 5'd0) mdl[addr3] = data3;
  end

  // What a read port must show, given the current inputs.
  function automatic logic [31:0] expect_rd(input logic [4:0] a);
    if (!rst_n)                          return 32'd0;
    if (a == 5'd0)                       return 32'd0;
    if (wr && addr3 != 5'd0 && a == addr3) return data3;
    return mdl[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Continuous compare against the model, away from the rising edge.
  always @(negedge clk) begin
    check("model_rd1", rdout1, expect_rd(addr1));
    check("model_rd2", rdout2, expect_rd(addr2));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    addr1 = 5'd7; addr2 = 5'd31;
    #1;
    check("reset_rd1", rdout1, 32'h0000_0000);
    check("reset_rd2", rdout2, 32'h0000_0000);

    // Basic write/read
    wr = 1'b1; addr3 = 5'd10; data3 = 32'h0000_FFFF;
    tick();
    wr = 1'b0; addr1 = 5'd10;
    #1 check("wr_r10", rdout1, 32'h0000_FFFF);
    wr = 1'b1; addr3 = 5'd14; data3 = 32'h0000_FF00;
    tick();
    wr = 1'b0; addr1 = 5'd14;
    #1 check("wr_r14", rdout1, 32'h0000_FF00);

    // Dual read
    wr = 1'b1; addr3 = 5'd31; data3 = 32'h0000_AAAA;
    tick();
    wr = 1'b0; addr1 = 5'd31; addr2 = 5'd10;
    #1 check("dual_rd1", rdout1, 32'h0000_AAAA);
    check("dual_rd2", rdout2, 32'h0000_FFFF);
    addr1 = 5'd14;
    #1 check("dual_rd1_chg", rdout1, 32'h0000_FF00);
    check("dual_rd2_hold", rdout2, 32'h0000_FFFF);

    // Non-interference
    wr = 1'b1; addr3 = 5'd1; data3 = 32'h0000_8888;
    #1 check("nonint_rd1", rdout1, 32'h0000_FF00);
    check("nonint_rd2", rdout2, 32'h0000_FFFF);
    tick();
    wr = 1'b0; addr1 = 5'd1;
    #1 check("nonint_r1", rdout1, 32'h0000_8888);

    // Bypass
    wr = 1'b1; addr3 = 5'd1; data3 = 32'h1234_5678;
    #1 check("bypass_rd1", rdout1, 32'h1234_5678);
    addr2 = 5'd1;
    #1 check("bypass_rd2", rdout2, 32'h1234_5678);
    tick();

    // r0 hardwired, bypass inactive for r0
    wr = 1'b1; addr3 = 5'd0; data3 = 32'hDEAD_BEEF; addr1 = 5'd0; addr2 = 5'd0;
    #1 check("r0_byp_rd1", rdout1, 32'h0000_0000);
    check("r0_byp_rd2", rdout2, 32'h0000_0000);
    tick();
    wr = 1'b0;
    #1 check("r0_rd1", rdout1, 32'h0000_0000);
    check("r0_rd2", rdout2, 32'h0000_0000);

    // Write-enable gating
    wr = 1'b0; addr3 = 5'd10; data3 = 32'hFFFF_FFFF;
    repeat (3) tick();
    addr1 = 5'd10;
    #1 check("gate_r10", rdout1, 32'h0000_FFFF);

    // Randomized traffic, checked by the model every cycle
    for (int n = 0; n < 400; n++) begin
      wr    = ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0;
      addr3 = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      data3 = $urandom;
      addr1 = ($urandom_range(0, 3) == 0) ? addr3 : 5'($urandom_range(0, 31));
      addr2 = ($urandom_range(0, 3) == 0) ? addr3 : 5'($urandom_range(0, 31));
      tick();
    end

    // Known contents ahead of the mid-run reset
    wr = 1'b1; addr3 = 5'd1;  data3 = 32'h1111_1111; tick();
    addr3 = 5'd10; data3 = 32'hAAAA_0000; tick();
    addr3 = 5'd31; data3 = 32'h3131_3131; tick();
    wr = 1'b0; addr1 = 5'd31; addr2 = 5'd10;
    #1 check("pre_rst_r31", rdout1, 32'h3131_3131);

    // Mid-cycle reset: outputs drop with no clock edge
    #1 rst_n = 1'b0;
    #1 check("rst_r31", rdout1, 32'h0000_0000);
    check("rst_r10", rdout2, 32'h0000_0000);
    addr1 = 5'd1;
    #1 check("rst_r1", rdout1, 32'h0000_0000);
    // Write attempted during reset: no bypass, no store
    wr = 1'b1; addr3 = 5'd31; data3 = 32'h5A5A_5A5A; addr1 = 5'd31;
    #1 check("rst_no_byp", rdout1, 32'h0000_0000);
    @(negedge clk);
    #1 rst_n = 1'b1; wr = 1'b0;
    #1 check("rst_no_store", rdout1, 32'h0000_0000);

    // First write after release lands on the first rising edge
    wr = 1'b1; addr3 = 5'd5; data3 = 32'hCAFE_F00D;
    tick();
    wr = 1'b0; addr1 = 5'd5;
    #1 check("post_rst_wr", rdout1, 32'hCAFE_F00D);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
